// File: rtl/cgra_stream_port_pkg.sv
// Shared types and constants for the CGRA stream port: run-state encoding,
// error flag bit positions and the default word width.
package cgra_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int ERR_UNDERFLOW  = 0;
    localparam int ERR_OVERFLOW   = 1;
    localparam int DATA_W_DEFAULT = 512;

endpackage

// File: rtl/cgra_stream_port_if.sv
// CGRA-side and host-side stream signals of the stream port.
// The slave modport is the port itself; the master modport is whatever
// drives it (CGRA array plus host).
interface cgra_stream_port_if #(
    parameter int DATA_W = 512
);
    logic              available_read;
    logic [DATA_W-1:0] rd_data;
    logic              req_rd_data;
    logic              available_write;
    logic [DATA_W-1:0] wr_data;
    logic              req_wr_data;
    logic              host_in_valid;
    logic              host_in_ready;
    logic [DATA_W-1:0] host_in_data;
    logic              host_out_valid;
    logic              host_out_ready;
    logic [DATA_W-1:0] host_out_data;

    modport slave (
        output available_read, rd_data,
        input  req_rd_data,
        output available_write,
        input  wr_data, req_wr_data,
        input  host_in_valid, host_in_data,
        output host_in_ready,
        output host_out_valid, host_out_data,
        input  host_out_ready
    );

    modport master (
        input  available_read, rd_data,
        output req_rd_data,
        input  available_write,
        output wr_data, req_wr_data,
        output host_in_valid, host_in_data,
        input  host_in_ready,
        input  host_out_valid, host_out_data,
        output host_out_ready
    );
endinterface

// File: rtl/cgra_stream_port_fifo.sv
// Show-ahead synchronous FIFO. The head word is always presented on pop_data;
// pop advances it. Pointers carry one extra wrap bit so full and empty are
// distinguishable without a separate counter. Push while full and pop while
// empty are ignored.
module cgra_sync_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cgra_stream_port.sv
// Memory-side responder for the CGRA data ports. A read FIFO is filled by the
// host and drained by the CGRA; a write FIFO is filled by the CGRA and drained
// by the host. IDLE/RUN/DRAIN brackets a run from start to cgra_done and waits
// for the results to leave before pulsing finish.
// Optional build macro CGRA_STREAM_PORT_STATS_EN adds rd_count/wr_count.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no run; host may preload the read FIFO
// ST_RUN   | CGRA may read and write words
// ST_DRAIN | CGRA done; waiting for the host to empty the write FIFO
module cgra_stream_port
    import cgra_stream_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int RD_DEPTH = 16,
    parameter int WR_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cgra_done,
    cgra_stream_port_if.slave sp,
    output logic        busy,
    output logic        finish,
    output logic [1:0]  err
`ifdef CGRA_STREAM_PORT_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);
    state_t            state_q, state_d;
    logic [1:0]        err_q, err_d;
    logic              run_start;
    logic              in_run;
    logic              rd_full, rd_empty, rd_push, rd_pop;
    logic              wr_full, wr_empty, wr_push, wr_pop;
    logic [DATA_W-1:0] rd_head, wr_head;

    assign in_run    = (state_q == ST_RUN);
    assign run_start = (state_q == ST_IDLE) && start;

    assign sp.available_read  = in_run && !rd_empty;
    assign sp.available_write = in_run && !wr_full;
    assign sp.host_in_ready   = !rd_full && (state_q != ST_DRAIN);
    assign sp.host_out_valid  = !wr_empty;
    // Data outputs are forced to zero while invalid so nothing stale leaks out.
    assign sp.rd_data         = sp.available_read ? rd_head : '0;
    assign sp.host_out_data   = sp.host_out_valid ? wr_head : '0;

    assign rd_push = sp.host_in_valid && sp.host_in_ready;
    assign rd_pop  = sp.req_rd_data && sp.available_read;
    assign wr_push = sp.req_wr_data && sp.available_write;
    assign wr_pop  = sp.host_out_valid && sp.host_out_ready;

    assign busy = (state_q != ST_IDLE);
    assign err  = err_q;

    cgra_sync_fifo #(.DATA_W(DATA_W), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (rd_push),
        .push_data (sp.host_in_data),
        .pop       (rd_pop),
        .pop_data  (rd_head),
        .full      (rd_full),
        .empty     (rd_empty)
    );

    cgra_sync_fifo #(.DATA_W(DATA_W), .DEPTH(WR_DEPTH)) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (wr_push),
        .push_data (sp.wr_data),
        .pop       (wr_pop),
        .pop_data  (wr_head),
        .full      (wr_full),
        .empty     (wr_empty)
    );

    // Run sequencing; finish is asserted combinationally in the exit cycle.
    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (cgra_done) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (wr_empty) begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sticky error flags: cleared by an accepted start, then new events OR in.
    always_comb begin
        err_d = run_start ? 2'b00 : err_q;
        if (sp.req_rd_data && !sp.available_read)  err_d[ERR_UNDERFLOW] = 1'b1;
        if (sp.req_wr_data && !sp.available_write) err_d[ERR_OVERFLOW]  = 1'b1;
    end

    // State and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

`ifdef CGRA_STREAM_PORT_STATS_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // Word counters; wrap naturally at 2^32 and restart with each run.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (run_start) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end else begin
            if (rd_pop)  rd_cnt_d = rd_cnt_q + 32'd1;
            if (wr_push) wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule
